// File: rtl/kyber_pmul_sequencer.sv
// Command sequencer for the 4-PE Kyber polynomial multiplier: stages operands, runs
// FNTT/PWM2/INTT on the core and streams the result back. Option: KYBER_SEQ_WATCHDOG_EN.
module kyber_pmul_sequencer #(
  parameter int unsigned PE_NUMBER   = 4,
  parameter int unsigned WORDS       = 64,
  parameter int unsigned DONE_MASK   = 2,
  parameter int unsigned RD_LAT      = 3,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [12*PE_NUMBER-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [12*PE_NUMBER-1:0]   out_data,
  output logic                      busy,
  output logic                      err,
  output logic                      load_a_f,
  output logic                      load_a_i,
  output logic                      load_b_f,
  output logic                      load_b_i,
  output logic                      read_a,
  output logic                      read_b,
  output logic                      start_ab,
  output logic                      start_fntt,
  output logic                      start_pwm2,
  output logic                      start_intt,
  output logic [12*PE_NUMBER-1:0]   core_din,
  input  logic [12*PE_NUMBER-1:0]   core_dout,
  input  logic                      core_done
);

  localparam int unsigned DW = 12 * PE_NUMBER;
  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned SW = $clog2(WORDS + RD_LAT + DONE_MASK + 2);

  typedef enum logic [3:0] {
    StIdle, StFillA, StPushA, StGapA, StFillB, StPushB, StGapB,
    StFnttA, StFnttB, StPwm2, StIntt, StWait, StRead, StDrain
  } state_e;

  state_e          r_state, w_state_d, r_op;
  logic            r_mode;
  logic [AW-1:0]   r_wr_cnt, r_rd_cnt;
  logic [SW-1:0]   r_step;
  logic [DW-1:0]   r_buf [WORDS];

  logic            w_fill, w_cap, w_buf_we, w_done_ok, w_timeout;
  logic [AW-1:0]   w_push_idx;
  logic            w_load_a_f, w_load_b_f, w_load_b_i, w_read_a;
  logic            w_start_ab, w_start_fntt, w_start_pwm2, w_start_intt;
  logic [DW-1:0]   w_din;

  assign w_fill     = (r_state == StFillA) || (r_state == StFillB);
  assign w_cap      = (r_state == StRead) && (r_step >= SW'(RD_LAT + 1));
  assign w_buf_we   = (w_fill && in_valid) || w_cap;
  assign w_push_idx = AW'(r_step - SW'(1));
  // core_done is only honoured once the mask window after the pulse has elapsed
  assign w_done_ok  = (r_state == StWait) && core_done && (r_step > SW'(DONE_MASK));

`ifdef KYBER_SEQ_WATCHDOG_EN
  logic [12:0] r_wdog;
  logic        r_err;

  assign w_timeout = (r_state == StWait) && !w_done_ok && (r_wdog == 13'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (r_state == StWait) ? r_wdog + 13'd1 : '0;
      if (r_state == StIdle && cmd_valid) r_err <= 1'b0;
      else if (w_timeout)                 r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (cmd_valid) w_state_d = StFillA;
      StFillA: if (in_valid && r_wr_cnt == AW'(WORDS - 1)) w_state_d = StPushA;
      StPushA: if (r_step == SW'(WORDS)) w_state_d = StGapA;
      StGapA:  if (r_step == SW'(1)) w_state_d = StFillB;
      StFillB: if (in_valid && r_wr_cnt == AW'(WORDS - 1)) w_state_d = StPushB;
      StPushB: if (r_step == SW'(WORDS)) w_state_d = StGapB;
      StGapB:  if (r_step == SW'(1)) w_state_d = StFnttA;
      StFnttA, StFnttB, StPwm2, StIntt: w_state_d = StWait;
      StWait: begin
        if (w_done_ok) begin
          case (r_op)
            StFnttA: w_state_d = r_mode ? StPwm2 : StFnttB;
            StFnttB: w_state_d = StPwm2;
            StPwm2:  w_state_d = StIntt;
            default: w_state_d = StRead;
          endcase
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      StRead:  if (r_step == SW'(RD_LAT + WORDS)) w_state_d = StDrain;
      StDrain: if (out_ready && r_rd_cnt == AW'(WORDS - 1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Core-side values are decoded here and registered below, so each pulse lasts one cycle.
  always_comb begin
    w_load_a_f   = 1'b0;
    w_load_b_f   = 1'b0;
    w_load_b_i   = 1'b0;
    w_read_a     = 1'b0;
    w_start_ab   = 1'b0;
    w_start_fntt = 1'b0;
    w_start_pwm2 = 1'b0;
    w_start_intt = 1'b0;
    w_din        = '0;
    case (r_state)
      StPushA: begin
        if (r_step == '0) w_load_a_f = 1'b1;
        else              w_din      = r_buf[w_push_idx];
      end
      StPushB: begin
        if (r_step == '0) begin
          w_load_b_f = !r_mode;
          w_load_b_i = r_mode;
        end else begin
          w_din = r_buf[w_push_idx];
        end
      end
      StFnttA: w_start_fntt = 1'b1;
      StFnttB: begin
        w_start_fntt = 1'b1;
        w_start_ab   = 1'b1;
      end
      StPwm2:  w_start_pwm2 = 1'b1;
      StIntt:  w_start_intt = 1'b1;
      StRead:  w_read_a     = (r_step == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_a_f   <= 1'b0;
      load_b_f   <= 1'b0;
      load_b_i   <= 1'b0;
      read_a     <= 1'b0;
      start_ab   <= 1'b0;
      start_fntt <= 1'b0;
      start_pwm2 <= 1'b0;
      start_intt <= 1'b0;
      core_din   <= '0;
    end else begin
      load_a_f   <= w_load_a_f;
      load_b_f   <= w_load_b_f;
      load_b_i   <= w_load_b_i;
      read_a     <= w_read_a;
      start_ab   <= w_start_ab;
      start_fntt <= w_start_fntt;
      start_pwm2 <= w_start_pwm2;
      start_intt <= w_start_intt;
      core_din   <= w_din;
    end
  end

  assign load_a_i = 1'b0;
  assign read_b   = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode   <= 1'b0;
      r_op     <= StIdle;
      r_step   <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (r_state == StIdle && cmd_valid) r_mode <= cmd_mode;
      if (r_state == StFnttA || r_state == StFnttB || r_state == StPwm2 || r_state == StIntt) begin
        r_op <= r_state;
      end
      if (w_state_d != r_state) begin
        r_step   <= '0;
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end else begin
        // Step saturates in WAIT once the done mask has expired
        if (r_state != StWait || r_step <= SW'(DONE_MASK)) r_step <= r_step + 1'b1;
        if (w_buf_we) r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_state == StDrain && out_ready) r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_wr_cnt] <= w_fill ? in_data : core_dout;
  end

  assign cmd_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign in_ready  = w_fill;
  assign out_valid = (r_state == StDrain);
  assign out_data  = (r_state == StDrain) ? r_buf[r_rd_cnt] : '0;

endmodule

// File: tb/tb_kyber_pmul_sequencer.sv
// Directed bench for kyber_pmul_sequencer with a behavioural core stub whose result is A^B.
module tb_kyber_pmul_sequencer;
  localparam int DW = 48;
  localparam int RD_LAT = 3;
  localparam int DONE_MASK = 2;
  localparam int DLAT = 8;
`ifdef KYBER_SEQ_WATCHDOG_EN
  localparam int WDOG = 100;
`else
  localparam int WDOG = 4096;
`endif

  logic clk, reset;
  logic cmd_valid, cmd_ready, cmd_mode;
  logic in_valid, in_ready, out_valid, out_ready, busy, err;
  logic [DW-1:0] in_data, out_data, core_din, core_dout;
  logic load_a_f, load_a_i, load_b_f, load_b_i, read_a, read_b;
  logic start_ab, start_fntt, start_pwm2, start_intt, core_done;

  kyber_pmul_sequencer #(
    .PE_NUMBER(4), .WORDS(64), .DONE_MASK(DONE_MASK), .RD_LAT(RD_LAT), .WDOG_CYCLES(WDOG)
  ) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .err(err), .load_a_f(load_a_f), .load_a_i(load_a_i), .load_b_f(load_b_f),
    .load_b_i(load_b_i), .read_a(read_a), .read_b(read_b), .start_ab(start_ab),
    .start_fntt(start_fntt), .start_pwm2(start_pwm2), .start_intt(start_intt),
    .core_din(core_din), .core_dout(core_dout), .core_done(core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [DW-1:0] opa [64];
  logic [DW-1:0] opb [64];

  // Core stub: captures loaded words, answers starts with a done pulse, returns A^B on read.
  logic [DW-1:0] a_mem [64];
  logic [DW-1:0] b_mem [64];
  int cyc = 0;
  int la, lb, rd_ph, dn, last_st, min_gap;
  int n_laf, n_lai, n_lbf, n_lbi, n_fntt, n_pwm2, n_intt, n_rda, n_rdb;
  logic [1:0] ab_log;
  bit done_en = 1'b1, done_stuck = 1'b0, model_clr = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (model_clr) begin
      la = 0; lb = 0; rd_ph = 0; dn = 0; last_st = -1; min_gap = 1000; ab_log = 2'b00;
      n_laf = 0; n_lai = 0; n_lbf = 0; n_lbi = 0; n_fntt = 0; n_pwm2 = 0; n_intt = 0;
      n_rda = 0; n_rdb = 0;
      core_done <= 1'b0;
      core_dout <= '0;
    end else begin
      if (la >= 1) begin a_mem[la-1] = core_din; la = (la == 64) ? 0 : la + 1; end
      if (lb >= 1) begin b_mem[lb-1] = core_din; lb = (lb == 64) ? 0 : lb + 1; end
      if (load_a_f || load_a_i) la = 1;
      if (load_b_f || load_b_i) lb = 1;
      n_laf += int'(load_a_f); n_lai += int'(load_a_i);
      n_lbf += int'(load_b_f); n_lbi += int'(load_b_i);
      n_fntt += int'(start_fntt); n_pwm2 += int'(start_pwm2); n_intt += int'(start_intt);
      n_rda += int'(read_a); n_rdb += int'(read_b);
      if (start_fntt) ab_log = {ab_log[0], start_ab};
      if (start_fntt || start_pwm2 || start_intt) begin
        if (last_st >= 0 && cyc - last_st < min_gap) min_gap = cyc - last_st;
        last_st = cyc;
        dn = 1;
      end else if (dn > 0) begin
        dn = (dn == DLAT) ? 0 : dn + 1;
      end
      core_done <= done_stuck || (done_en && dn == DLAT);
      if (rd_ph > 0) rd_ph = (rd_ph == RD_LAT + 64) ? 0 : rd_ph + 1;
      if (read_a) rd_ph = 1;
      core_dout <= (rd_ph >= RD_LAT && rd_ph < RD_LAT + 64) ?
                   (a_mem[rd_ph-RD_LAT] ^ b_mem[rd_ph-RD_LAT]) : '0;
    end
  end

  task automatic clear_model();
    model_clr = 1'b1;
    @(posedge clk); #1;
    model_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic m);
    int g = 0;
    while (!cmd_ready && g < 2000) begin @(posedge clk); #1; g++; end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("busy_after_cmd", busy, 1);
  endtask

  task automatic fill(input int which, input bit toggle);
    int k = 0, g = 0;
    bit ph = 1'b1;
    logic rdy;
    while (k < 64 && g < 3000) begin
      in_valid = toggle ? ph : 1'b1;
      in_data  = (which == 0) ? opa[k] : opb[k];
      rdy = in_ready;
      @(posedge clk); #1;
      g++;
      if (in_valid && rdy) k++;
      ph = !ph;
    end
    in_valid = 1'b0;
    check_eq("fill_done", k, 64);
  endtask

  task automatic collect(input bit stall);
    int k = 0, g = 0, st = 0;
    logic v;
    logic [DW-1:0] d;
    while (k < 64 && g < 5000) begin
      out_ready = (stall && k == 20 && st < 10) ? 1'b0 : 1'b1;
      v = out_valid;
      d = out_data;
      @(posedge clk); #1;
      g++;
      if (v && out_ready) begin
        check_eq($sformatf("word%0d", k), d, opa[k] ^ opb[k]);
        k++;
      end else if (v) begin
        st++;
        check_eq("stall_hold", d, opa[20] ^ opb[20]);
      end
    end
    out_ready = 1'b0;
    check_eq("drain_done", k, 64);
    check_eq("stall_cycles", st, stall ? 10 : 0);
    check_eq("busy_end", busy, 0);
  endtask

  task automatic check_counts(input bit full);
    check_eq("n_load_a_f", n_laf, 1);
    check_eq("n_load_a_i", n_lai, 0);
    check_eq("n_load_b_f", n_lbf, full ? 1 : 0);
    check_eq("n_load_b_i", n_lbi, full ? 0 : 1);
    check_eq("n_fntt", n_fntt, full ? 2 : 1);
    check_eq("fntt_ab_order", ab_log, full ? 2'b01 : 2'b00);
    check_eq("n_pwm2", n_pwm2, 1);
    check_eq("n_intt", n_intt, 1);
    check_eq("n_read_a", n_rda, 1);
    check_eq("n_read_b", n_rdb, 0);
  endtask

  task automatic run(input logic m, input bit toggle, input bit stall, input bit stuck);
    clear_model();
    done_stuck = stuck;
    send_cmd(m);
    fill(0, toggle);
    fill(1, 1'b0);
    collect(stall);
    check_counts(!m);
    if (stuck) check_eq("mask_gap", min_gap, DONE_MASK + 3);
    done_stuck = 1'b0;
  endtask

  function automatic logic [9:0] pulses();
    return {load_a_f, load_a_i, load_b_f, load_b_i, read_a, read_b,
            start_ab, start_fntt, start_pwm2, start_intt};
  endfunction

  initial begin
    int g;
    int t0;
    for (int k = 0; k < 64; k++) begin
      opa[k] = {12'(4*k), 12'(4*k+1), 12'(4*k+2), 12'(4*k+3)};
      opb[k] = {12'(7*k+100), 12'(3000-k), 12'(k) ^ 12'h5a5, 12'(29*k)};
    end
    reset = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0;
    model_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_pulses", pulses(), 0);
    check_eq("rst_core_din", core_din, 0);
    reset = 1'b1;
    model_clr = 1'b0;

    run(1'b1, 1'b0, 1'b0, 1'b0);   // half mode
    run(1'b0, 1'b0, 1'b0, 1'b1);   // full mode, core_done stuck high
    run(1'b1, 1'b1, 1'b1, 1'b0);   // toggled fill, output stall at word 20

    // Reset while waiting on PWM2
    clear_model();
    send_cmd(1'b0);
    fill(0, 1'b0);
    fill(1, 1'b0);
    g = 0;
    while (n_pwm2 == 0 && g < 2000) begin @(posedge clk); #1; g++; end
    check_eq("pwm2_seen", n_pwm2, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("arst_cmd_ready", cmd_ready, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_pulses", pulses(), 0);
    check_eq("arst_core_din", core_din, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    run(1'b0, 1'b0, 1'b0, 1'b0);   // full mode after abort

`ifdef KYBER_SEQ_WATCHDOG_EN
    clear_model();
    done_en = 1'b0;
    send_cmd(1'b0);
    fill(0, 1'b0);
    fill(1, 1'b0);
    g = 0;
    while (n_fntt == 0 && g < 2000) begin @(posedge clk); #1; g++; end
    t0 = cyc;
    g = 0;
    while (!err && g < 400) begin @(posedge clk); #1; g++; end
    check_eq("wdog_err", err, 1);
    check_eq("wdog_idle", busy, 0);
    check_eq("wdog_time", (cyc - t0 >= WDOG - 2) && (cyc - t0 <= WDOG + 2), 1);
    check_eq("wdog_no_pwm2", n_pwm2, 0);
    check_eq("wdog_no_drain", out_valid, 0);
    send_cmd(1'b0);
    check_eq("wdog_err_clear", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    done_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
